// File: rtl/bcd_display_mux.sv
// bcd_display_mux: scanned 7-segment driver with guard time, leading-zero blanking and per-frame snapshot
module bcd_display_mux #(
  parameter int N_DIGITS    = 4,
  parameter int SCAN_DIV    = 1000,
  parameter int GUARD_CYC   = 16,
  parameter int SEG_ACT_LOW = 1,
  parameter int AN_ACT_LOW  = 1
) (
  input  logic                  ck,
  input  logic                  rst_n,
  input  logic                  enb,
  input  logic [4*N_DIGITS-1:0] bcd,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_done
);
  typedef enum logic [1:0] {OFF, GUARD, SHOW} state_t;
  localparam int IW = $clog2(N_DIGITS);
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic SL = SEG_ACT_LOW != 0;
  localparam logic AL = AN_ACT_LOW != 0;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_DIGITS - 1);
  localparam logic [PW-1:0] LAST_PC = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] LAST_GUARD = PW'(GUARD_CYC - 1);
  state_t st, st_n;
  logic [IW-1:0] idx, idx_n;
  logic [PW-1:0] pc, pc_n;
  logic [4*N_DIGITS-1:0] sb, sb_n;
  logic [N_DIGITS-1:0] sdp, sdp_n, blank, an_h;
  logic slz, slz_n, load, on, fd_n;
  logic [3:0] nib;
  logic [6:0] dec;
  always_comb begin
    st_n = st;
    idx_n = idx;
    pc_n = pc;
    if (!enb) begin
      st_n = OFF;
      idx_n = '0;
      pc_n = '0;
    end else if (st == OFF) begin
      st_n = GUARD;
      idx_n = '0;
      pc_n = '0;
    end else if (st == SHOW && pc == LAST_PC) begin
      st_n = GUARD;
      pc_n = '0;
      idx_n = (idx == LAST_IDX) ? '0 : idx + 1'b1;
    end else begin
      pc_n = pc + 1'b1;
      st_n = (st == GUARD && pc == LAST_GUARD) ? SHOW : st;
    end
  end
  // Latch inputs once per frame, as the scan (re)enters digit 0, so a frame never tears
  assign load  = st_n == GUARD && idx_n == '0 && st != GUARD;
  assign sb_n  = load ? bcd : sb;
  assign sdp_n = load ? dp_in : sdp;
  assign slz_n = load ? blank_lz : slz;
  assign nib   = sb_n[{idx_n, 2'b00} +: 4];
  always_comb begin
    case (nib)
      4'd0:    dec = 7'b1111110;
      4'd1:    dec = 7'b0110000;
      4'd2:    dec = 7'b1101101;
      4'd3:    dec = 7'b1111001;
      4'd4:    dec = 7'b0110011;
      4'd5:    dec = 7'b1011011;
      4'd6:    dec = 7'b1011111;
      4'd7:    dec = 7'b1110000;
      4'd8:    dec = 7'b1111111;
      4'd9:    dec = 7'b1111011;
      default: dec = 7'b0000001;
    endcase
  end
  always_comb begin
    logic acc;
    acc = 1'b1;
    blank = '0;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      acc = acc & (sb_n[4*i +: 4] == 4'd0);
      blank[i] = slz_n & acc;
    end
  end
  assign on   = st_n != OFF;
  assign an_h = (st_n == SHOW && !blank[idx_n]) ? N_DIGITS'(1) << idx_n : '0;
  assign fd_n = st_n == SHOW && idx_n == LAST_IDX && pc_n == LAST_PC;
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      st <= OFF;
      idx <= '0;
      pc <= '0;
      sb <= '0;
      sdp <= '0;
      slz <= 1'b0;
      seg <= {7{SL}};
      dp <= SL;
      an <= {N_DIGITS{AL}};
      frame_done <= 1'b0;
    end else begin
      st <= st_n;
      idx <= idx_n;
      pc <= pc_n;
      sb <= sb_n;
      sdp <= sdp_n;
      slz <= slz_n;
      seg <= {7{SL}} ^ (on ? dec : 7'd0);
      dp <= SL ^ (on & sdp_n[idx_n]);
      an <= {N_DIGITS{AL}} ^ an_h;
      frame_done <= fd_n;
    end
  end
endmodule

// File: tb/tb_bcd_display_mux.sv
// tb_bcd_display_mux: table-driven scoreboard bench for the scanned display driver
module tb_bcd_display_mux;
  logic ck = 1'b0, clk_en = 1'b0, rst_n = 1'b1, enb = 1'b0, blank_lz = 1'b0;
  logic [15:0] bcd = '0;
  logic [3:0] dp_in = '0, an;
  logic [6:0] seg;
  logic dp, frame_done;
  int tests = 0, fails = 0;
  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  dpi;
    logic        lz;
    logic [27:0] segs;
    logic [3:0]  lit;
  } vec_t;
  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       segchk;
    logic       dp;
    logic       fd;
  } exp_t;
  localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010, S3 = 7'b0000110,
    S4 = 7'b1001100, S5 = 7'b0100100, S6 = 7'b0100000, S7 = 7'b0001111, S8 = 7'b0000000,
    S9 = 7'b0000100, SD = 7'b1111110;
  vec_t vt[8];
  exp_t q[$];
  bcd_display_mux #(.N_DIGITS(4), .SCAN_DIV(8), .GUARD_CYC(2), .SEG_ACT_LOW(1), .AN_ACT_LOW(1)) dut (
    .ck(ck), .rst_n(rst_n), .enb(enb), .bcd(bcd), .dp_in(dp_in), .blank_lz(blank_lz),
    .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
  );
  always begin
    #5;
    if (clk_en) ck = ~ck;
  end
  task automatic apply(input int v);
    bcd = vt[v].bcd;
    dp_in = vt[v].dpi;
    blank_lz = vt[v].lz;
  endtask
  task automatic push_frame(input int v);
    exp_t e;
    for (int k = 0; k < 32; k++) begin
      int d, p;
      d = k / 8;
      p = k % 8;
      e.an = (p >= 2 && vt[v].lit[d]) ? ~(4'b0001 << d) : 4'hF;
      e.seg = vt[v].segs[d*7 +: 7];
      e.segchk = vt[v].lit[d];
      e.dp = ~vt[v].dpi[d];
      e.fd = (k == 31);
      q.push_back(e);
    end
  endtask
  task automatic push_off(input int n);
    exp_t e;
    e = '{4'hF, 7'h7F, 1'b1, 1'b1, 1'b0};
    repeat (n) q.push_back(e);
  endtask
  task automatic check_now(input string name, input exp_t e);
    tests++;
    if (an !== e.an || (e.segchk && seg !== e.seg) || dp !== e.dp || frame_done !== e.fd) begin
      fails++;
      $display("FAIL %s t=%0t: an=%b seg=%b dp=%b fd=%b, want an=%b seg=%b dp=%b fd=%b",
               name, $time, an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
    end
  endtask
  task automatic run_cycles(input string name, input int n);
    exp_t e;
    repeat (n) begin
      @(posedge ck);
      #1;
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL %s: scoreboard empty, got an=%b, want an expectation", name, an);
      end else begin
        e = q.pop_front();
        check_now(name, e);
      end
    end
  endtask
  task automatic go_off();
    enb = 1'b0;
    push_off(2);
    run_cycles("off", 2);
  endtask
  task automatic run_vec(input string name, input int v);
    apply(v);
    enb = 1'b1;
    push_frame(v);
    run_cycles(name, 32);
    go_off();
  endtask
  initial begin
    exp_t off_e;
    off_e = '{4'hF, 7'h7F, 1'b1, 1'b1, 1'b0};
    vt[0] = '{16'h1234, 4'b0000, 1'b0, {S1, S2, S3, S4}, 4'b1111};
    vt[1] = '{16'h0040, 4'b0000, 1'b1, {S0, S0, S4, S0}, 4'b0011};
    vt[2] = '{16'h0000, 4'b0000, 1'b1, {S0, S0, S0, S0}, 4'b0001};
    vt[3] = '{16'h00B0, 4'b0010, 1'b0, {S0, S0, SD, S0}, 4'b1111};
    vt[4] = '{16'h5678, 4'b1001, 1'b1, {S5, S6, S7, S8}, 4'b1111};
    vt[5] = '{16'h0900, 4'b0000, 1'b1, {S0, S9, S0, S0}, 4'b0111};
    vt[6] = '{16'h0900, 4'b0100, 1'b0, {S0, S9, S0, S0}, 4'b1111};
    vt[7] = '{16'h5678, 4'b0000, 1'b0, {S5, S6, S7, S8}, 4'b1111};
    #2 rst_n = 1'b0;
    #1 check_now("reset_no_clock", off_e);
    clk_en = 1'b1;
    #20 rst_n = 1'b1;
    push_off(3);
    run_cycles("idle", 3);
    for (int v = 0; v < 7; v++) run_vec($sformatf("vec%0d", v), v);
    apply(0);
    enb = 1'b1;
    push_frame(0);
    run_cycles("snap_a", 12);
    bcd = 16'h5678;
    run_cycles("snap_a", 20);
    push_frame(7);
    run_cycles("snap_b", 32);
    go_off();
    apply(0);
    enb = 1'b1;
    push_frame(0);
    run_cycles("enb_drop_pre", 20);
    enb = 1'b0;
    q.delete();
    push_off(40);
    run_cycles("enb_drop_off", 40);
    enb = 1'b1;
    push_frame(0);
    run_cycles("reenable", 32);
    push_frame(0);
    run_cycles("mid_reset_pre", 27);
    #2 rst_n = 1'b0;
    #1 check_now("mid_reset_async", off_e);
    q.delete();
    @(negedge ck);
    rst_n = 1'b1;
    push_frame(0);
    run_cycles("after_reset", 32);
    go_off();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
